// File: rtl/alu_arbiter_if.sv
// Handshake and ALU-side bundle for alu_arbiter: two request channels,
// two response channels and the shared-ALU operand/result wires.
interface alu_arbiter_if #(
    parameter int DATA_W = 16,
    parameter int IMM_W  = 6,
    parameter int OP_W   = 3,
    parameter int FN_W   = 4
);
    logic              req0_valid;
    logic              req0_ready;
    logic [DATA_W-1:0] req0_rs1;
    logic [DATA_W-1:0] req0_rs2;
    logic [IMM_W-1:0]  req0_imm;
    logic [OP_W-1:0]   req0_op;
    logic [FN_W-1:0]   req0_func4;

    logic              req1_valid;
    logic              req1_ready;
    logic [DATA_W-1:0] req1_rs1;
    logic [DATA_W-1:0] req1_rs2;
    logic [IMM_W-1:0]  req1_imm;
    logic [OP_W-1:0]   req1_op;
    logic [FN_W-1:0]   req1_func4;

    logic              rsp0_valid;
    logic              rsp0_ready;
    logic [DATA_W-1:0] rsp0_data;
    logic              rsp1_valid;
    logic              rsp1_ready;
    logic [DATA_W-1:0] rsp1_data;

    logic [DATA_W-1:0] alu_rs1_data;
    logic [DATA_W-1:0] alu_rs2_data;
    logic [IMM_W-1:0]  alu_imm;
    logic [OP_W-1:0]   alu_op;
    logic [FN_W-1:0]   alu_func4;
    logic [DATA_W-1:0] alu_o;

    // Arbiter side
    modport slave (
        input  req0_valid, req0_rs1, req0_rs2, req0_imm, req0_op, req0_func4,
        output req0_ready,
        input  req1_valid, req1_rs1, req1_rs2, req1_imm, req1_op, req1_func4,
        output req1_ready,
        output rsp0_valid, rsp0_data,
        input  rsp0_ready,
        output rsp1_valid, rsp1_data,
        input  rsp1_ready,
        output alu_rs1_data, alu_rs2_data, alu_imm, alu_op, alu_func4,
        input  alu_o
    );

    // Requester / ALU side
    modport master (
        output req0_valid, req0_rs1, req0_rs2, req0_imm, req0_op, req0_func4,
        input  req0_ready,
        output req1_valid, req1_rs1, req1_rs2, req1_imm, req1_op, req1_func4,
        input  req1_ready,
        input  rsp0_valid, rsp0_data,
        output rsp0_ready,
        input  rsp1_valid, rsp1_data,
        output rsp1_ready,
        input  alu_rs1_data, alu_rs2_data, alu_imm, alu_op, alu_func4,
        output alu_o
    );
endinterface

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one combinational ALU between two requesters,
// with a one-entry response buffer per requester. Optional: ALU_ARB_STATS_EN.
module alu_arbiter #(
    parameter int DATA_W = 16,
    parameter int IMM_W  = 6,
    parameter int OP_W   = 3,
    parameter int FN_W   = 4
) (
    input  logic        clk,
    input  logic        rst,
    alu_arbiter_if.slave bus
`ifdef ALU_ARB_STATS_EN
    ,
    output logic [15:0] stat_grant0,
    output logic [15:0] stat_grant1,
    output logic [15:0] stat_conflict
`endif
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } buf_state_t;

    buf_state_t        state0;
    buf_state_t        state1;
    logic [DATA_W-1:0] data0;
    logic [DATA_W-1:0] data1;
    logic              last_grant;   // 0: req0 won last, 1: req1 won last
    logic              elig0;
    logic              elig1;
    logic              grant0;
    logic              grant1;

    // A full buffer being drained this cycle can be refilled in the same cycle.
    always_comb begin
        elig0  = bus.req0_valid && ((state0 == EMPTY) || bus.rsp0_ready);
        elig1  = bus.req1_valid && ((state1 == EMPTY) || bus.rsp1_ready);
        grant0 = elig0 && (!elig1 || last_grant);
        grant1 = elig1 && (!elig0 || !last_grant);
    end

    assign bus.req0_ready = grant0;
    assign bus.req1_ready = grant1;
    assign bus.rsp0_valid = (state0 == FULL);
    assign bus.rsp1_valid = (state1 == FULL);
    assign bus.rsp0_data  = data0;
    assign bus.rsp1_data  = data1;

    // Requester 0 drives the ALU whenever requester 1 is not granted.
    always_comb begin
        if (grant1) begin
            bus.alu_rs1_data = bus.req1_rs1;
            bus.alu_rs2_data = bus.req1_rs2;
            bus.alu_imm      = bus.req1_imm;
            bus.alu_op       = bus.req1_op;
            bus.alu_func4    = bus.req1_func4;
        end else begin
            bus.alu_rs1_data = bus.req0_rs1;
            bus.alu_rs2_data = bus.req0_rs2;
            bus.alu_imm      = bus.req0_imm;
            bus.alu_op       = bus.req0_op;
            bus.alu_func4    = bus.req0_func4;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state0     <= EMPTY;
            state1     <= EMPTY;
            data0      <= '0;
            data1      <= '0;
            last_grant <= 1'b1;
        end else begin
            if (grant0) begin
                state0 <= FULL;
                data0  <= bus.alu_o;
            end else if (bus.rsp0_ready) begin
                state0 <= EMPTY;
            end

            if (grant1) begin
                state1 <= FULL;
                data1  <= bus.alu_o;
            end else if (bus.rsp1_ready) begin
                state1 <= EMPTY;
            end

            if (grant0) begin
                last_grant <= 1'b0;
            end else if (grant1) begin
                last_grant <= 1'b1;
            end
        end
    end

`ifdef ALU_ARB_STATS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_grant0   <= '0;
            stat_grant1   <= '0;
            stat_conflict <= '0;
        end else begin
            if (grant0 && (stat_grant0 != '1)) begin
                stat_grant0 <= stat_grant0 + 16'd1;
            end
            if (grant1 && (stat_grant1 != '1)) begin
                stat_grant1 <= stat_grant1 + 16'd1;
            end
            if (elig0 && elig1 && (stat_conflict != '1)) begin
                stat_conflict <= stat_conflict + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: reset, single requests, alternation,
// backpressure with same-cycle refill, pointer hold, and optional stats.
module tb_alu_arbiter;

    logic clk;
    logic rst;
    int   tests;
    int   fails;

    alu_arbiter_if #(.DATA_W(16), .IMM_W(6), .OP_W(3), .FN_W(4)) bus ();

`ifdef ALU_ARB_STATS_EN
    logic [15:0] stat_grant0;
    logic [15:0] stat_grant1;
    logic [15:0] stat_conflict;
`endif

    alu_arbiter #(.DATA_W(16), .IMM_W(6), .OP_W(3), .FN_W(4)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
`ifdef ALU_ARB_STATS_EN
        ,
        .stat_grant0(stat_grant0),
        .stat_grant1(stat_grant1),
        .stat_conflict(stat_conflict)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference ALU: ADD / SUB / INV
    always_comb begin
        case (bus.alu_func4)
            4'd0:    bus.alu_o = bus.alu_rs1_data + bus.alu_rs2_data;
            4'd1:    bus.alu_o = bus.alu_rs1_data - bus.alu_rs2_data;
            4'd2:    bus.alu_o = ~bus.alu_rs1_data;
            default: bus.alu_o = 16'd0;
        endcase
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic set0(input logic v, input logic [15:0] a, input logic [15:0] b, input logic [3:0] f);
        bus.req0_valid = v;
        bus.req0_rs1   = a;
        bus.req0_rs2   = b;
        bus.req0_func4 = f;
    endtask

    task automatic set1(input logic v, input logic [15:0] a, input logic [15:0] b, input logic [3:0] f);
        bus.req1_valid = v;
        bus.req1_rs1   = a;
        bus.req1_rs2   = b;
        bus.req1_func4 = f;
    endtask

    // Advance one clock; inputs may change 1 ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        tests = 0;
        fails = 0;
        rst = 1'b1;
        set0(1'b0, 16'd0, 16'd0, 4'd0);
        set1(1'b0, 16'd0, 16'd0, 4'd0);
        bus.req0_imm   = '0;
        bus.req0_op    = '0;
        bus.req1_imm   = '0;
        bus.req1_op    = '0;
        bus.rsp0_ready = 1'b1;
        bus.rsp1_ready = 1'b1;
        tick();
        tick();

        chk("reset_rsp0_valid", 32'(bus.rsp0_valid), 32'd0);
        chk("reset_rsp1_valid", 32'(bus.rsp1_valid), 32'd0);
        chk("reset_rsp0_data", 32'(bus.rsp0_data), 32'd0);
        chk("reset_rsp1_data", 32'(bus.rsp1_data), 32'd0);

        // Reset mid-operation
        rst = 1'b0;
        set0(1'b1, 16'd3, 16'd3, 4'd0);
        #1;
        chk("midop_req0_ready", 32'(bus.req0_ready), 32'd1);
        tick();
        chk("midop_rsp0_valid_pre", 32'(bus.rsp0_valid), 32'd1);
        set0(1'b0, 16'd3, 16'd3, 4'd0);
        rst = 1'b1;
        #1;
        chk("midop_rsp0_valid", 32'(bus.rsp0_valid), 32'd0);
        chk("midop_rsp0_data", 32'(bus.rsp0_data), 32'd0);
        rst = 1'b0;
        set0(1'b1, 16'd3, 16'd3, 4'd0);
        set1(1'b1, 16'd5, 16'd4, 4'd1);
        #1;
        chk("post_rst_req0_ready", 32'(bus.req0_ready), 32'd1);
        chk("post_rst_req1_ready", 32'(bus.req1_ready), 32'd0);
        tick();
        chk("post_rst_rsp0_data", 32'(bus.rsp0_data), 32'd6);
        chk("post_rst_2nd_req1_ready", 32'(bus.req1_ready), 32'd1);
        chk("post_rst_2nd_req0_ready", 32'(bus.req0_ready), 32'd0);
        tick();
        chk("post_rst_rsp1_data", 32'(bus.rsp1_data), 32'd1);
        chk("post_rst_rsp0_drained", 32'(bus.rsp0_valid), 32'd0);

        // Single requester
        set1(1'b0, 16'd5, 16'd4, 4'd1);
        #1;
        chk("single0_ready", 32'(bus.req0_ready), 32'd1);
        tick();
        chk("single0_rsp_valid", 32'(bus.rsp0_valid), 32'd1);
        chk("single0_rsp_data", 32'(bus.rsp0_data), 32'd6);
        set0(1'b0, 16'd3, 16'd3, 4'd0);
        set1(1'b1, 16'd5, 16'd4, 4'd1);
        #1;
        chk("single1_ready", 32'(bus.req1_ready), 32'd1);
        tick();
        chk("single1_rsp_valid", 32'(bus.rsp1_valid), 32'd1);
        chk("single1_rsp_data", 32'(bus.rsp1_data), 32'd1);

        // Conflict: strict alternation starting with req0
        set0(1'b1, 16'd3, 16'd3, 4'd0);
        set1(1'b1, 16'd2, 16'd0, 4'd2);
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("alt_req0_ready", 32'(bus.req0_ready), (i % 2 == 0) ? 32'd1 : 32'd0);
            chk("alt_req1_ready", 32'(bus.req1_ready), (i % 2 == 0) ? 32'd0 : 32'd1);
            tick();
            if (i % 2 == 0) begin
                chk("alt_rsp0_data", 32'(bus.rsp0_data), 32'd6);
                chk("alt_rsp0_valid", 32'(bus.rsp0_valid), 32'd1);
            end else begin
                chk("alt_rsp1_data", 32'(bus.rsp1_data), 32'd65533);
                chk("alt_rsp1_valid", 32'(bus.rsp1_valid), 32'd1);
            end
        end

        // Backpressure on response 0
        #1;
        chk("bp_first_req0_ready", 32'(bus.req0_ready), 32'd1);
        tick();
        chk("bp_rsp0_data", 32'(bus.rsp0_data), 32'd6);
        bus.rsp0_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("bp_req0_ready", 32'(bus.req0_ready), 32'd0);
            chk("bp_req1_ready", 32'(bus.req1_ready), 32'd1);
            tick();
            chk("bp_rsp0_hold_valid", 32'(bus.rsp0_valid), 32'd1);
            chk("bp_rsp0_hold_data", 32'(bus.rsp0_data), 32'd6);
            chk("bp_rsp1_data", 32'(bus.rsp1_data), 32'd65533);
        end
        set0(1'b1, 16'd3, 16'd4, 4'd0);
        bus.rsp0_ready = 1'b1;
        #1;
        chk("refill_req0_ready", 32'(bus.req0_ready), 32'd1);
        chk("refill_rsp0_valid", 32'(bus.rsp0_valid), 32'd1);
        tick();
        chk("refill_rsp0_valid_next", 32'(bus.rsp0_valid), 32'd1);
        chk("refill_rsp0_data", 32'(bus.rsp0_data), 32'd7);

        // Pointer hold across idle cycles
        set0(1'b0, 16'd3, 16'd3, 4'd0);
        #1;
        chk("hold_req1_grant", 32'(bus.req1_ready), 32'd1);
        tick();
        set1(1'b0, 16'd2, 16'd0, 4'd2);
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("idle_no_grant", 32'({bus.req0_ready, bus.req1_ready}), 32'd0);
            tick();
        end
        set0(1'b1, 16'd3, 16'd3, 4'd0);
        set1(1'b1, 16'd2, 16'd0, 4'd2);
        #1;
        chk("hold_req0_after_idle", 32'(bus.req0_ready), 32'd1);
        chk("hold_req1_after_idle", 32'(bus.req1_ready), 32'd0);
        tick();

`ifdef ALU_ARB_STATS_EN
        rst = 1'b1;
        #1;
        chk("stat_reset_g0", 32'(stat_grant0), 32'd0);
        rst = 1'b0;
        set0(1'b1, 16'd3, 16'd3, 4'd0);
        set1(1'b1, 16'd2, 16'd0, 4'd2);
        for (int i = 0; i < 4; i++) tick();
        set1(1'b0, 16'd2, 16'd0, 4'd2);
        for (int i = 0; i < 2; i++) tick();
        chk("stat_grant0", 32'(stat_grant0), 32'd4);
        chk("stat_grant1", 32'(stat_grant1), 32'd2);
        chk("stat_conflict", 32'(stat_conflict), 32'd4);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
